// File: rtl/drum_step_scheduler.sv
// rtl/drum_step_scheduler.sv - sample strobe divider and pattern-driven drum step sequencer
module drum_step_scheduler #(
    parameter int SAMPLE_DIV = 2084,
    parameter int TRACKS     = 4,
    parameter int STEPS      = 16,
    parameter int TEMPO_W    = 16
) (
    input  logic                                      clkin,
    input  logic                                      rstn,
    input  logic                                      run,
    input  logic [TEMPO_W-1:0]                        tempo_samples,
    input  logic                                      pat_we,
    input  logic [((TRACKS > 1) ? $clog2(TRACKS) : 1)-1:0] pat_track,
    input  logic [((STEPS > 1) ? $clog2(STEPS) : 1)-1:0]   pat_step,
    input  logic                                      pat_bit,
    output logic                                      sample_tick,
    output logic                                      step_tick,
    output logic [((STEPS > 1) ? $clog2(STEPS) : 1)-1:0]   step_idx,
    output logic [TRACKS-1:0]                         trig,
    output logic                                      playing
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIV_W-1:0]     r_div_cnt;
    logic                 w_sample_tick;
    logic [TEMPO_W-1:0]   r_smp_cnt;
    logic [TEMPO_W-1:0]   r_tempo_eff;
    logic [TEMPO_W-1:0]   w_tempo_clamp;
    logic                 w_step_end;
    logic                 w_step_start;
    logic [IDX_W-1:0]     r_step_idx;
    logic [IDX_W-1:0]     w_next_idx;
    logic [TRACKS-1:0]    w_column;
    logic                 r_step_tick;
    logic [TRACKS-1:0]    r_trig;
    logic [STEPS-1:0]     r_pat [TRACKS];

    // The strobe is decoded straight from the divider so it is low while reset holds the count at 0.
    assign w_sample_tick = (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // Zero or one sample per step would collapse the step, so the latched length never drops below 2.
    assign w_tempo_clamp = (tempo_samples < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_samples;
    assign w_step_end    = (r_smp_cnt == (r_tempo_eff - TEMPO_W'(1)));

    // ARM always launches step 0; PLAY advances and wraps naturally at the power-of-two step count.
    assign w_next_idx = (r_state == S_ARM) ? '0 : (r_step_idx + 1'b1);

    assign sample_tick = w_sample_tick;
    assign step_tick   = r_step_tick;
    assign step_idx    = r_step_idx;
    assign trig        = r_trig;
    assign playing     = (r_state == S_ARM) || (r_state == S_PLAY);

    // Free-running sample divider, independent of run.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_div_cnt <= '0;
        end else if (w_sample_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and step-start qualification; dropping run takes priority over a step start.
    always_comb begin
        w_state_nxt  = r_state;
        w_step_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (!run) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sample_tick) begin
                    w_step_start = 1'b1;
                    w_state_nxt  = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!run) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sample_tick && w_step_end) begin
                    w_step_start = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Samples elapsed within the current step; held at 0 outside PLAY.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_smp_cnt <= '0;
        end else if (w_step_start || (r_state != S_PLAY)) begin
            r_smp_cnt <= '0;
        end else if (w_sample_tick) begin
            r_smp_cnt <= r_smp_cnt + 1'b1;
        end
    end

    // Step length is sampled only at step start so mid-step tempo edits wait for the next step.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_tempo_eff <= '0;
        end else if (w_step_start) begin
            r_tempo_eff <= w_tempo_clamp;
        end
    end

    // Pattern column for the step about to start, read from the pre-write memory contents.
    always_comb begin
        w_column = '0;
        for (int t = 0; t < TRACKS; t++) begin
            w_column[t] = r_pat[t][w_next_idx];
        end
    end

    // Registered step outputs: one-cycle pulses one cycle after the qualifying sample strobe.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_step_tick <= 1'b0;
            r_trig      <= '0;
            r_step_idx  <= '0;
        end else begin
            r_step_tick <= w_step_start;
            r_trig      <= w_step_start ? w_column : '0;
            if (w_step_start) begin
                r_step_idx <= w_next_idx;
            end else if (w_state_nxt == S_IDLE) begin
                r_step_idx <= '0;
            end
        end
    end

    // Pattern memory: cleared by reset, written synchronously in any state.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < TRACKS; t++) begin
                r_pat[t] <= '0;
            end
        end else if (pat_we) begin
            r_pat[pat_track][pat_step] <= pat_bit;
        end
    end

endmodule

// File: tb/tb_drum_step_scheduler.sv
// tb/tb_drum_step_scheduler.sv - scoreboard bench for drum_step_scheduler
module tb_drum_step_scheduler;

    localparam int SD = 4;

    logic        clkin = 1'b0;
    logic        rstn = 1'b0;
    logic        run = 1'b0;
    logic [15:0] tempo_samples = '0;
    logic        pat_we = 1'b0;
    logic [1:0]  pat_track = '0;
    logic [3:0]  pat_step = '0;
    logic        pat_bit = 1'b0;
    logic        sample_tick;
    logic        step_tick;
    logic [3:0]  step_idx;
    logic [3:0]  trig;
    logic        playing;

    typedef struct {
        int cyc;
        int idx;
        int trig;
    } ev_t;

    ev_t      exp_q[$];
    ev_t      m_e;
    bit [15:0] pat_m [4];
    int       cyc;
    int       n_checks = 0;
    int       n_fail = 0;
    int       t0;

    drum_step_scheduler #(
        .SAMPLE_DIV (SD),
        .TRACKS     (4),
        .STEPS      (16),
        .TEMPO_W    (16)
    ) dut (
        .clkin         (clkin),
        .rstn          (rstn),
        .run           (run),
        .tempo_samples (tempo_samples),
        .pat_we        (pat_we),
        .pat_track     (pat_track),
        .pat_step      (pat_step),
        .pat_bit       (pat_bit),
        .sample_tick   (sample_tick),
        .step_tick     (step_tick),
        .step_idx      (step_idx),
        .trig          (trig),
        .playing       (playing)
    );

    always #5 clkin = ~clkin;

    // Cycle number since reset release; equals the divider count modulo SD.
    always @(posedge clkin or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    // Every step pulse must match the oldest predicted step start.
    always @(negedge clkin) begin
        if (rstn && (step_tick || (trig != 4'd0))) begin
            if (exp_q.size() == 0) begin
                check_value("extra_step", int'({step_tick, trig}), 0);
            end else begin
                m_e = exp_q.pop_front();
                check_value("step_cyc", cyc, m_e.cyc);
                check_value("step_idx", int'(step_idx), m_e.idx);
                check_value("trig", int'(trig), m_e.trig);
                check_value("step_tick", int'(step_tick), 1);
            end
        end
    end

    task automatic clear_model();
        for (int t = 0; t < 4; t++) pat_m[t] = '0;
    endtask

    task automatic do_reset();
        @(negedge clkin);
        rstn = 1'b0;
        run = 1'b0;
        pat_we = 1'b0;
        tempo_samples = '0;
        exp_q.delete();
        clear_model();
        #1;
        check_value("rst_outs", int'({sample_tick, step_tick, step_idx, trig, playing}), 0);
        repeat (2) @(negedge clkin);
        rstn = 1'b1;
    endtask

    task automatic write_cell(input int t, input int s, input bit b);
        @(negedge clkin);
        pat_we = 1'b1;
        pat_track = t[1:0];
        pat_step = s[3:0];
        pat_bit = b;
        pat_m[t][s] = b;
        @(negedge clkin);
        pat_we = 1'b0;
    endtask

    task automatic load_pattern();
        write_cell(0, 0, 1'b1);
        write_cell(0, 4, 1'b1);
        write_cell(0, 8, 1'b1);
        write_cell(0, 12, 1'b1);
        write_cell(2, 1, 1'b1);
        write_cell(1, 7, 1'b1);
        write_cell(3, 15, 1'b1);
    endtask

    // Raise run; first step pulse follows the first sample strobe seen in ARM.
    task automatic start_run(input int tempo, output int first);
        int n;
        @(negedge clkin);
        tempo_samples = tempo[15:0];
        run = 1'b1;
        n = cyc + 1;
        while ((n % SD) != (SD - 1)) n++;
        first = n + 1;
    endtask

    task automatic expect_steps(input int first, input int idx0, input int n, input int tempo);
        int te;
        te = (tempo < 2) ? 2 : tempo;
        for (int i = 0; i < n; i++) begin
            ev_t e;
            e.cyc = first + i * SD * te;
            e.idx = (idx0 + i) % 16;
            e.trig = 0;
            for (int t = 0; t < 4; t++) begin
                if (pat_m[t][e.idx]) e.trig = e.trig | (1 << t);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int target);
        int k;
        k = 0;
        while ((cyc < target) && (k < 5000)) begin
            @(negedge clkin);
            k++;
        end
        check_value("wait_cyc", (cyc >= target) ? 1 : 0, 1);
    endtask

    task automatic stop_at(input int last);
        wait_cyc(last);
        run = 1'b0;
        repeat (2) @(negedge clkin);
        check_value("stop_playing", int'(playing), 0);
        check_value("stop_idx", int'(step_idx), 0);
        check_value("q_drain", exp_q.size(), 0);
        repeat (20) @(negedge clkin);
        check_value("idle_idx", int'(step_idx), 0);
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clkin);
            check_value("smp_tick", int'(sample_tick), ((cyc % SD) == (SD - 1)) ? 1 : 0);
            check_value("idle_playing", int'(playing), 0);
        end

        load_pattern();
        start_run(2, t0);
        expect_steps(t0, 0, 4, 2);
        @(negedge clkin);
        check_value("arm_playing", int'(playing), 1);
        stop_at(t0 + 3 * 8);

        do_reset();
        load_pattern();
        start_run(3, t0);
        expect_steps(t0, 0, 18, 3);
        stop_at(t0 + 17 * 12);

        do_reset();
        load_pattern();
        start_run(2, t0);
        expect_steps(t0, 0, 1, 2);
        expect_steps(t0 + 8, 1, 3, 5);
        wait_cyc(t0 + 2);
        tempo_samples = 16'd5;
        stop_at(t0 + 8 + 2 * 20);

        do_reset();
        load_pattern();
        start_run(0, t0);
        expect_steps(t0, 0, 4, 0);
        wait_cyc(t0 + 23);
        pat_we = 1'b1;
        pat_track = 2'd1;
        pat_step = 4'd3;
        pat_bit = 1'b1;
        pat_m[1][3] = 1'b1;
        expect_steps(t0 + 32, 4, 16, 0);
        @(negedge clkin);
        pat_we = 1'b0;
        stop_at(t0 + 32 + 15 * 8);

        do_reset();
        load_pattern();
        start_run(2, t0);
        expect_steps(t0, 0, 2, 2);
        wait_cyc(t0 + 15);
        check_value("pre_rst_idx", int'(step_idx), 1);
        check_value("pre_rst_playing", int'(playing), 1);
        check_value("pre_rst_tick", int'(sample_tick), 1);
        rstn = 1'b0;
        run = 1'b0;
        exp_q.delete();
        clear_model();
        #1;
        check_value("async_rst", int'({sample_tick, step_tick, step_idx, trig, playing}), 0);
        repeat (3) @(negedge clkin);
        check_value("rst_hold", int'({sample_tick, step_tick, step_idx, trig, playing}), 0);
        rstn = 1'b1;
        start_run(2, t0);
        expect_steps(t0, 0, 2, 2);
        stop_at(t0 + 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
